// File: rtl/matrix_key_scan_if.sv
// Key event handshake between the keypad scanner and its consumer.
// The scanner presents key_code/key_valid and holds them until key_ready is seen.
interface matrix_key_scan_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: row-by-row scan, press/release debounce and
// a valid/ready key event port. Row drive and column sense are active-low.
module matrix_key_scan #(
    parameter int unsigned SCAN_TIME = 4,
    parameter int unsigned MASK_TIME = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        col_n,
    output logic [3:0]        row_n,
    output logic              busy,
    matrix_key_scan_if.master key_if
);

    localparam int unsigned MAX_TIME = (SCAN_TIME > MASK_TIME) ? SCAN_TIME : MASK_TIME;
    localparam int unsigned CNT_W    = $clog2(MAX_TIME + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TIME - 1);
    localparam logic [CNT_W-1:0] MASK_CNT  = CNT_W'(MASK_TIME);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        REPORT,
        RELEASE
    } state_t;

    state_t           state;
    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [1:0]       row;
    logic [1:0]       col;
    logic [CNT_W-1:0] cnt;

    // Lowest-index active (low) column of a sample.
    function automatic logic [1:0] low_col(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    // Two-flop synchronizer; idles high like the pulled-up columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    // Scan / debounce / report controller; every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            row_n            <= 4'b0000;
            row              <= 2'd0;
            col              <= 2'd0;
            cnt              <= '0;
            busy             <= 1'b0;
            key_if.key_code  <= 4'h0;
            key_if.key_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    row_n <= 4'b0000;
                    cnt   <= '0;
                    if (col_s != 4'hF) begin
                        state <= SCAN;
                        row   <= 2'd0;
                        row_n <= row_drive(2'd0);
                        busy  <= 1'b1;
                    end
                end

                // Columns are judged only at the end of a slot so the
                // synchronizer has caught up with the new row drive.
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (col_s != 4'hF) begin
                            col   <= low_col(col_s);
                            state <= DEBOUNCE;
                        end else if (row == 2'd3) begin
                            state <= IDLE;
                            row_n <= 4'b0000;
                            busy  <= 1'b0;
                        end else begin
                            row   <= row + 2'd1;
                            row_n <= row_drive(row + 2'd1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (col_s[col]) begin
                        state <= IDLE;
                        row_n <= 4'b0000;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == MASK_CNT) begin
                        state            <= REPORT;
                        row_n            <= 4'b0000;
                        cnt              <= '0;
                        key_if.key_code  <= {row, col};
                        key_if.key_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Event stays pending regardless of the key; only the consumer clears it.
                REPORT: begin
                    row_n <= 4'b0000;
                    if (key_if.key_valid && key_if.key_ready) begin
                        key_if.key_valid <= 1'b0;
                        state            <= RELEASE;
                        cnt              <= '0;
                    end
                end

                // Wait for the whole pad to be released for MASK_TIME cycles.
                RELEASE: begin
                    row_n <= 4'b0000;
                    if (cnt == MASK_CNT) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (col_s == 4'hF) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end

                default: begin
                    state            <= IDLE;
                    row_n            <= 4'b0000;
                    cnt              <= '0;
                    busy             <= 1'b0;
                    key_if.key_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: keypad model, event scoreboard and per-cycle
// protocol checks, with directed scenarios followed by random press episodes.
module tb_matrix_key_scan;

    localparam int unsigned SCAN_TIME = 4;
    localparam int unsigned MASK_TIME = 5;

    logic        clk;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        busy;
    logic [15:0] pressed;
    int          rdy_mode;
    int          n_checks;
    int          n_fail;
    int          ev_cnt;
    logic [3:0]  last_code;
    logic [3:0]  exp_q[$];

    matrix_key_scan_if key_if();

    matrix_key_scan #(
        .SCAN_TIME(SCAN_TIME),
        .MASK_TIME(MASK_TIME)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .col_n (col_n),
        .row_n (row_n),
        .busy  (busy),
        .key_if(key_if)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Keypad: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            col_n[c] = 1'b1;
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference rule: first row in scan order, then lowest column == lowest row*4+col.
    function automatic logic [3:0] min_code(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return 4'(i);
        return 4'h0;
    endfunction

    function automatic logic legal_row(input logic [3:0] r);
        return (r == 4'hE) || (r == 4'hD) || (r == 4'hB) || (r == 4'h7);
    endfunction

    // Consumer ready: 0/1 forced, 2 random per cycle.
    initial begin
        key_if.key_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            key_if.key_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    // Per-cycle compare against the scoreboard and protocol rules.
    initial begin
        logic       prev_hold;
        logic [3:0] prev_code;
        prev_hold = 1'b0;
        prev_code = 4'h0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_hold = 1'b0;
            end else begin
                if (!busy) begin
                    check("idle_rows", 32'(row_n), 32'h0);
                    check("idle_valid", 32'(key_if.key_valid), 32'h0);
                end else if (row_n != 4'h0) begin
                    check("row_single", 32'(legal_row(row_n)), 32'h1);
                end
                if (prev_hold) begin
                    check("hold_valid", 32'(key_if.key_valid), 32'h1);
                    check("hold_code", 32'(key_if.key_code), 32'(prev_code));
                end
                if (key_if.key_valid && key_if.key_ready) begin
                    ev_cnt++;
                    last_code = key_if.key_code;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: got code %0h, expected no event at %0t",
                                 key_if.key_code, $time);
                    end else begin
                        check("event_code", 32'(key_if.key_code), 32'(exp_q.pop_front()));
                    end
                end
                prev_hold = key_if.key_valid && !key_if.key_ready;
                prev_code = key_if.key_code;
            end
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 300) begin
            tick(1);
            w++;
        end
        check(name, 32'(w < 300), 32'h1);
    endtask

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!key_if.key_valid && n < budget) begin
            tick(1);
            n++;
        end
        if (!key_if.key_valid) check(name, 32'(key_if.key_valid), 32'h1);
    endtask

    initial begin
        int n;
        int ev0;
        n_checks = 0;
        n_fail   = 0;
        ev_cnt   = 0;
        last_code = 4'h0;
        pressed  = 16'h0;
        rdy_mode = 1;
        rst      = 1'b1;

        // Reset then idle
        tick(10);
        check("rst_row_n", 32'(row_n), 32'h0);
        check("rst_valid", 32'(key_if.key_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_code", 32'(key_if.key_code), 32'h0);
        rst = 1'b0;
        tick(200);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_events", 32'(ev_cnt), 32'h0);

        // Minimum latency for key 0: 2 + 1 + 4 + 5 + 1
        ev0 = ev_cnt;
        exp_q.push_back(4'h0);
        pressed = 16'h0001;
        wait_valid("lat0_timeout", 40, n);
        check("latency_key0", 32'(n), 32'd13);
        check("code_key0", 32'(key_if.key_code), 32'h0);
        tick(20);
        pressed = 16'h0;
        wait_idle("lat0_drain");
        check("lat0_events", 32'(ev_cnt - ev0), 32'd1);

        // Row 2 / col 1, ready high
        ev0 = ev_cnt;
        exp_q.push_back(4'h9);
        pressed = 16'h0200;
        wait_valid("k9_timeout", 60, n);
        check("latency_key9", 32'(n), 32'd21);
        check("code_key9", 32'(key_if.key_code), 32'h9);
        tick(40);
        pressed = 16'h0;
        n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        check("release_to_idle", 32'(n <= int'(MASK_TIME) + 3), 32'h1);
        check("k9_events", 32'(ev_cnt - ev0), 32'd1);

        // Bounce on row 1 / col 3
        ev0 = ev_cnt;
        pressed = 16'h0080; tick(1);
        pressed = 16'h0;    tick(2);
        pressed = 16'h0080; tick(3);
        pressed = 16'h0;    tick(80);
        check("bounce_events", 32'(ev_cnt - ev0), 32'd0);
        check("bounce_busy", 32'(busy), 32'h0);

        // Delayed ready, key released while pending
        ev0 = ev_cnt;
        rdy_mode = 0;
        exp_q.push_back(4'h0);
        pressed = 16'h0001;
        tick(20);
        pressed = 16'h0;
        tick(30);
        check("delay_valid", 32'(key_if.key_valid), 32'h1);
        check("delay_code", 32'(key_if.key_code), 32'h0);
        rdy_mode = 1;
        tick(3);
        check("delay_cleared", 32'(key_if.key_valid), 32'h0);
        wait_idle("delay_drain");
        check("delay_events", 32'(ev_cnt - ev0), 32'd1);

        // Rows 1 and 3 on col 2; partial release must not produce a second event
        ev0 = ev_cnt;
        exp_q.push_back(4'h6);
        pressed = 16'h4040;
        tick(60);
        check("multi_code", 32'(last_code), 32'h6);
        check("multi_first", 32'(ev_cnt - ev0), 32'd1);
        pressed = 16'h4000;
        tick(60);
        check("multi_held", 32'(ev_cnt - ev0), 32'd1);
        pressed = 16'h0;
        wait_idle("multi_drain");
        check("multi_events", 32'(ev_cnt - ev0), 32'd1);

        // Reset in the middle of the debounce count
        ev0 = ev_cnt;
        pressed = 16'h0001;
        tick(9);
        check("mid_rst_none", 32'(ev_cnt - ev0), 32'd0);
        check("mid_rst_valid", 32'(key_if.key_valid), 32'h0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(4'h0);
        n = 0;
        while (ev_cnt == ev0 && n < 60) begin
            tick(1);
            n++;
        end
        check("rescan_events", 32'(ev_cnt - ev0), 32'd1);
        check("rescan_code", 32'(last_code), 32'h0);
        tick(20);
        pressed = 16'h0;
        wait_idle("rescan_drain");
        check("rescan_total", 32'(ev_cnt - ev0), 32'd1);

        // Random episodes against the scoreboard
        rdy_mode = 2;
        for (int ep = 0; ep < 30; ep++) begin
            int          kind;
            int          exp_ev;
            logic [15:0] m;
            logic [3:0]  mc;
            ev0  = ev_cnt;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                exp_ev  = 0;
                pressed = 16'(1) << $urandom_range(0, 15);
                tick(int'($urandom_range(1, MASK_TIME)));
                pressed = 16'h0;
            end else begin
                exp_ev = 1;
                m = 16'h0;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    m = m | (16'(1) << $urandom_range(0, 15));
                mc = min_code(m);
                exp_q.push_back(mc);
                pressed = m;
                tick(30 + int'($urandom_range(0, 30)));
                if (kind == 3 && $countones(m) > 1) begin
                    pressed = m & ~(16'(1) << mc);
                    tick(int'($urandom_range(10, 40)));
                end
                pressed = 16'h0;
            end
            tick(10);
            wait_idle("episode_drain");
            check("episode_events", 32'(ev_cnt - ev0), 32'(exp_ev));
            tick(5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_key_scan.md
MATRIX_KEY_SCAN -- requirements
Module: matrix_key_scan

Interface
REQ-001 Parameter SCAN_TIME, default 4: clock cycles each row is driven during a scan. Legal values are 3 or more.
REQ-002 Parameter MASK_TIME, default 5: consecutive stable cycles required to accept a press or a release. Legal values are 1 or more.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 col_n  input  4  keypad column lines; active-low, pulled up externally, asynchronous to clk.
REQ-006 row_n  output  4  keypad row drive; active-low, registered.
REQ-007 key_code  output  4  accepted key, encoded as row*4+col.
REQ-008 key_valid  output  1  key_code holds a pending event.
REQ-009 key_ready  input  1  consumer accepts the event.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 col_n SHALL pass through a 2-flop synchronizer; the result is col_s, and all FSM decisions SHALL use col_s only.
REQ-012 The FSM SHALL have exactly five states: IDLE, SCAN, DEBOUNCE, REPORT and RELEASE.
REQ-013 IDLE: row_n=4'b0000; if col_s!=4'hF, the next state SHALL be SCAN with row index 0.
REQ-014 SCAN row drive: row_n SHALL have only bit r low (row 0 gives 4'b1110).
REQ-015 SCAN slot length: each row is held SCAN_TIME cycles, and col_s SHALL be sampled only on the last cycle of the slot.
REQ-016 SCAN sample result, any col_s bit low: latch r and the lowest-index low column c, clear the counter, and go to DEBOUNCE.
REQ-017 SCAN sample result, no bit low: advance to row r+1; after row 3, return to IDLE with no event.
REQ-018 DEBOUNCE: row_n SHALL keep row r driven.
REQ-019 DEBOUNCE counting: the counter SHALL increment each cycle col_s[c]=0.
REQ-020 DEBOUNCE reject: any cycle with col_s[c]=1 SHALL return the FSM to IDLE with no event.
REQ-021 DEBOUNCE accept: when the counter reaches MASK_TIME, on the next edge key_code SHALL equal {r,c}, key_valid SHALL be 1, and the state SHALL be REPORT.
REQ-022 REPORT hold: key_valid and key_code SHALL stay stable until the cycle with key_valid&&key_ready.
REQ-023 REPORT accept: on the edge of that cycle, key_valid SHALL drop to 0 and the state SHALL become RELEASE.
REQ-024 In REPORT, row_n=4'b0000; the key being released while the event is pending SHALL NOT cancel the event.
REQ-025 key_ready while key_valid=0 SHALL be ignored.
REQ-026 RELEASE: row_n=4'b0000; the counter SHALL increment while col_s==4'hF and clear on any low bit.
REQ-027 RELEASE exit: at MASK_TIME the FSM SHALL go to IDLE; no new event SHALL be produced while any key stays held.
REQ-028 Simultaneous keys: the first row in scan order wins, and within that row the lowest column wins; exactly one event SHALL be produced per press cycle.
REQ-029 Counter width: ceil(log2(max(SCAN_TIME,MASK_TIME)+1)) bits; the counter SHALL saturate and never wrap.
REQ-030 Minimum latency: from a clean key-0 press (col_n[0] low) to key_valid is 2 (sync) + 1 + SCAN_TIME + MASK_TIME + 1 cycles.

Reset
REQ-031 When rst=1 at a clock edge, the next state SHALL be state=IDLE, row_n=4'b0000, key_code=4'h0, key_valid=0, busy=0, counters=0 and synchronizer flops=4'hF.
REQ-032 rst SHALL take priority in every state: mid-DEBOUNCE or mid-REPORT the pending event is discarded and no key_valid pulse follows.
REQ-033 After rst is released, a key that is still held SHALL be rescanned from IDLE and reported once.

Verification (SCAN_TIME=4, MASK_TIME=5, clk period 20 ns)
REQ-034 Reset then idle: rst high 10 cycles with no key -> row_n=0000, key_valid=0, busy=0, and these hold for 200 cycles.
REQ-035 Clean press of row 2 / col 1, key_ready=1 -> exactly one key_valid pulse with key_code=4'h9; after release busy returns to 0 within MASK_TIME+3 cycles.
REQ-036 Bounce rejection: row 1 / col 3 toggled low 1 cycle, high 2 cycles, low 3 cycles, then released -> no key_valid.
REQ-037 Delayed ready: key row 0 / col 0 held, key_ready=0 for 50 cycles, key released at cycle 20 -> key_valid=1 with key_code=4'h0 stable until key_ready rises, then one event total.
REQ-038 Multi-key: rows 1 and 3, both col 2, pressed together -> key_code=4'h6 only, and no second event until all keys are released for 5 cycles.
REQ-039 Reset mid-DEBOUNCE: rst pulsed 1 cycle during the DEBOUNCE count, key still held -> no event before rst, and one event (key_code of that key) after rescan.
